// File: rtl/alu_16b_sync.sv
// alu_16b_sync: 16-op registered ALU with carry and op-class flags.
module alu_16b_sync #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALU_FUN,
   output logic [WIDTH-1:0] ALU_OUT,
   output logic             Carry_Flag,
   output logic             Arith_Flag,
   output logic             Logic_Flag,
   output logic             CMP_Flag,
   output logic             Shift_Flag
);
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] r;
   logic             c;
   always_comb begin
      sum = {1'b0, A} + {1'b0, B};
      r = '0;
      c = 1'b0;
      case (ALU_FUN)
         4'd0:  begin r = sum[WIDTH-1:0]; c = sum[WIDTH]; end
         4'd1:  begin r = A - B; c = A < B; end
         4'd2:  r = A * B;
         4'd3:  r = (B == '0) ? '1 : A / B;
         4'd4:  r = A & B;
         4'd5:  r = A | B;
         4'd6:  r = ~(A & B);
         4'd7:  r = ~(A | B);
         4'd8:  r = A ^ B;
         4'd9:  r = ~(A ^ B);
         4'd10: r = (A == B) ? WIDTH'(1) : '0;
         4'd11: r = (A > B) ? WIDTH'(2) : '0;
         4'd12: r = (A < B) ? WIDTH'(3) : '0;
         4'd13: r = A >> 1;
         4'd14: r = A << 1;
         default: r = '0;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!RST) begin
         ALU_OUT    <= '0;
         Carry_Flag <= 1'b0;
         Arith_Flag <= 1'b0;
         Logic_Flag <= 1'b0;
         CMP_Flag   <= 1'b0;
         Shift_Flag <= 1'b0;
      end else begin
         ALU_OUT    <= r;
         Carry_Flag <= c;
         Arith_Flag <= ALU_FUN <= 4'd3;
         Logic_Flag <= ALU_FUN >= 4'd4 && ALU_FUN <= 4'd9;
         CMP_Flag   <= ALU_FUN >= 4'd10 && ALU_FUN <= 4'd12;
         Shift_Flag <= ALU_FUN == 4'd13 || ALU_FUN == 4'd14;
      end
   end
endmodule

// File: tb/tb_alu_16b_sync.sv
// tb_alu_16b_sync: directed spec vectors plus random ops checked against an arithmetic model.
module tb_alu_16b_sync;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic [3:0]  ALU_FUN = '0;
   logic [15:0] ALU_OUT;
   logic        Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
   int          tests = 0, fails = 0;

   alu_16b_sync dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN),
      .ALU_OUT(ALU_OUT), .Carry_Flag(Carry_Flag), .Arith_Flag(Arith_Flag),
      .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag)
   );

   always #5 CLK = ~CLK;

   // Expected {result, carry, arith, logic, cmp, shift} from the op table in plain integer math.
   function automatic logic [20:0] model(input logic rst, input logic [3:0] f,
                                         input logic [15:0] a, input logic [15:0] b);
      int unsigned x = a, y = b, r = 0;
      bit c = 0;
      if (!rst) return '0;
      case (f)
         0: begin r = x + y; c = r > 65535; end
         1: begin r = x - y; c = x < y; end
         2: r = x * y;
         3: r = (y == 0) ? 65535 : x / y;
         4: r = x & y;
         5: r = x | y;
         6: r = ~(x & y);
         7: r = ~(x | y);
         8: r = x ^ y;
         9: r = ~(x ^ y);
         10: r = (x == y) ? 1 : 0;
         11: r = (x > y) ? 2 : 0;
         12: r = (x < y) ? 3 : 0;
         13: r = x / 2;
         14: r = x * 2;
         default: r = 0;
      endcase
      return {r[15:0], c, f <= 3, f >= 4 && f <= 9, f >= 10 && f <= 12, f == 13 || f == 14};
   endfunction

   task automatic step(input string tag, input logic rst, input logic [3:0] f,
                       input logic [15:0] a, input logic [15:0] b, input logic [20:0] exp);
      logic [20:0] got;
      RST = rst; ALU_FUN = f; A = a; B = b;
      @(posedge CLK);
      #1;
      got = {ALU_OUT, Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got out=%h flags=%b, expected out=%h flags=%b",
                tag, got[20:5], got[4:0], exp[20:5], exp[4:0]);
      end
   endtask

   initial begin
      logic [3:0]  f;
      logic [15:0] a, b;
      logic        r;
      step("rst0", 0, 4'd0, 16'hFFFF, 16'hFFFF, 21'd0);
      step("rst1", 0, 4'd0, 16'hFFFF, 16'hFFFF, 21'd0);
      step("rel",  1, 4'd0, 16'hFFFF, 16'hFFFF, {16'hFFFE, 5'b11000});
      step("add",  1, 4'd0, 16'hAF0A, 16'hF2CD, {16'hA1D7, 5'b11000});
      step("sub",  1, 4'd1, 16'hAF0A, 16'hF2CD, {16'hBC3D, 5'b11000});
      step("sub_nb", 1, 4'd1, 16'h0010, 16'h0003, {16'h000D, 5'b01000});
      step("mul",  1, 4'd2, 16'h36A9, 16'h034A, model(1, 4'd2, 16'h36A9, 16'h034A));
      step("div",  1, 4'd3, 16'hDEDB, 16'hDBD7, {16'h0001, 5'b01000});
      step("div0", 1, 4'd3, 16'h1234, 16'h0000, {16'hFFFF, 5'b01000});
      step("and",  1, 4'd4, 16'hCEDB, 16'h9BD7, {16'h8AD3, 5'b00100});
      step("or",   1, 4'd5, 16'hCEDB, 16'h9BD7, {16'hDFDF, 5'b00100});
      step("nand", 1, 4'd6, 16'hCEDB, 16'h9BD7, {16'h752C, 5'b00100});
      step("nor",  1, 4'd7, 16'hCEDB, 16'h9BD7, {16'h2020, 5'b00100});
      step("xor",  1, 4'd8, 16'hCEDB, 16'h9BD7, {16'h550C, 5'b00100});
      step("xnor", 1, 4'd9, 16'hCEDB, 16'h9BD7, {16'hAAF3, 5'b00100});
      step("eq_t", 1, 4'd10, 16'd8,  16'd8, {16'd1, 5'b00010});
      step("eq_f", 1, 4'd10, 16'd26, 16'd8, {16'd0, 5'b00010});
      step("gt_t", 1, 4'd11, 16'd26, 16'd8, {16'd2, 5'b00010});
      step("gt_f", 1, 4'd11, 16'd8,  16'd8, {16'd0, 5'b00010});
      step("lt_t", 1, 4'd12, 16'd5,  16'd8, {16'd3, 5'b00010});
      step("lt_f", 1, 4'd12, 16'd27, 16'd8, {16'd0, 5'b00010});
      step("shr",  1, 4'd13, 16'hE354, 16'hFFFF, {16'h71AA, 5'b00001});
      step("shl",  1, 4'd14, 16'hE354, 16'hFFFF, {16'hC6A8, 5'b00001});
      step("nop",  1, 4'd15, 16'hE354, 16'hFFFF, 21'd0);
      step("rst_dom", 0, 4'd0, 16'hFFFF, 16'h0001, 21'd0);
      step("post_rst", 1, 4'd5, 16'h0F00, 16'h00F0, {16'h0FF0, 5'b00100});
      for (int i = 0; i < 300; i++) begin
         f = 4'($urandom_range(0, 15));
         a = 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 16'(f == 3 ? 0 : a) : 16'($urandom);
         r = $urandom_range(0, 19) != 0;
         step($sformatf("rnd%0d_f%0d", i, f), r, f, a, b, model(r, f, a, b));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
